// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input stage: PS/2 scan codes, joystick bit
// positions, INP bus bit positions and the coin FSM state type.
package arcade_input_pkg;

    localparam logic [8:0] KEY_UP       = 9'h075;
    localparam logic [8:0] KEY_DOWN     = 9'h072;
    localparam logic [8:0] KEY_LEFT     = 9'h06B;
    localparam logic [8:0] KEY_RIGHT    = 9'h074;
    localparam logic [8:0] KEY_P1_TRIG1 = 9'h029;
    localparam logic [8:0] KEY_P1_TRIG2 = 9'h014;
    localparam logic [8:0] KEY_F1       = 9'h005;
    localparam logic [8:0] KEY_F2       = 9'h006;
    localparam logic [8:0] KEY_START1   = 9'h016;
    localparam logic [8:0] KEY_START2   = 9'h01E;
    localparam logic [8:0] KEY_P2_UP    = 9'h02D;
    localparam logic [8:0] KEY_P2_DOWN  = 9'h02B;
    localparam logic [8:0] KEY_P2_LEFT  = 9'h023;
    localparam logic [8:0] KEY_P2_RIGHT = 9'h034;
    localparam logic [8:0] KEY_P2_TRIG1 = 9'h01C;
    localparam logic [8:0] KEY_P2_TRIG2 = 9'h01B;
    localparam logic [8:0] KEY_COIN1    = 9'h02E;
    localparam logic [8:0] KEY_COIN2    = 9'h036;

    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_TRIG1  = 4;
    localparam int JOY_TRIG2  = 5;
    localparam int JOY_START1 = 6;
    localparam int JOY_START2 = 7;
    localparam int JOY_COIN   = 8;

    localparam int INP_UP    = 0;
    localparam int INP_RIGHT = 1;
    localparam int INP_DOWN  = 2;
    localparam int INP_LEFT  = 3;
    localparam int INP_TRIG1 = 4;
    localparam int INP_TRIG2 = 5;

    typedef enum logic [1:0] {COIN_IDLE, COIN_PULSE, COIN_GAP} coin_state_t;

    // Reorders the low joystick bits into the INP layout {trig2,trig1,left,down,right,up}.
    function automatic logic [5:0] joy_to_inp(input logic [5:0] j);
        return {j[JOY_TRIG2], j[JOY_TRIG1], j[JOY_LEFT], j[JOY_DOWN], j[JOY_RIGHT], j[JOY_UP]};
    endfunction

endpackage

// File: rtl/arcade_input_ctrl_if.sv
// Bundle of hps_io-side inputs and core-side INP outputs of the arcade input stage.
interface arcade_input_ctrl_if;
    logic [10:0] ps2_key;
    logic [15:0] joystk1;
    logic [15:0] joystk2;
    logic        cabinet;
    logic        autofire;
    logic [5:0]  INP0;
    logic [5:0]  INP1;
    logic [2:0]  INP2;
    logic        coin_busy;

    modport slave (
        input  ps2_key, joystk1, joystk2, cabinet, autofire,
        output INP0, INP1, INP2, coin_busy
    );

    modport master (
        output ps2_key, joystk1, joystk2, cabinet, autofire,
        input  INP0, INP1, INP2, coin_busy
    );
endinterface

// File: rtl/coin_pulser.sv
// Turns coin-button rising edges into fixed-length, spaced coin pulses through
// a small saturating pending-coin counter.
//
//   state      | meaning
//   COIN_IDLE  | no pulse; dequeues one pending coin when available
//   COIN_PULSE | coin output high for COIN_ON cycles
//   COIN_GAP   | coin output forced low for COIN_OFF cycles
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter int COIN_ON     = 4800000,
    parameter int COIN_OFF    = 4800000,
    parameter int MAX_PENDING = 3
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_coin_raw,
    output logic o_coin,
    output logic o_busy
);
    localparam int CMAX = (COIN_ON > COIN_OFF) ? COIN_ON : COIN_OFF;
    localparam int TW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int PW   = $clog2(MAX_PENDING + 1);

    coin_state_t   r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [PW-1:0] r_pending, w_pending_nxt;
    logic          r_coin_d;
    logic          w_req, w_deq;

    assign w_req = i_coin_raw & ~r_coin_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= COIN_IDLE;
            r_timer   <= '0;
            r_pending <= '0;
            r_coin_d  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_pending <= w_pending_nxt;
            r_coin_d  <= i_coin_raw;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_deq       = 1'b0;
        case (r_state)
            COIN_IDLE: begin
                if (r_pending != '0) begin
                    w_deq       = 1'b1;
                    w_state_nxt = COIN_PULSE;
                    w_timer_nxt = TW'(COIN_ON - 1);
                end
            end
            COIN_PULSE: begin
                if (r_timer == '0) begin
                    w_state_nxt = COIN_GAP;
                    w_timer_nxt = TW'(COIN_OFF - 1);
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            COIN_GAP: begin
                if (r_timer == '0) begin
                    w_state_nxt = COIN_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: w_state_nxt = COIN_IDLE;
        endcase
    end

    // A request coinciding with a dequeue leaves the count unchanged.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_req && !w_deq && (r_pending != PW'(MAX_PENDING))) begin
            w_pending_nxt = r_pending + PW'(1);
        end else if (w_deq && !w_req) begin
            w_pending_nxt = r_pending - PW'(1);
        end
    end

    assign o_coin = (r_state == COIN_PULSE);
    assign o_busy = (r_state != COIN_IDLE) || (r_pending != '0);

endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade input conditioning: PS/2 key map, joystick merge and coin pulsing.
// Optional autofire on trig1 is compiled in with ARC_INPUT_AUTOFIRE_EN.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int COIN_ON       = 4800000,
    parameter int COIN_OFF      = 4800000,
    parameter int MAX_PENDING   = 3,
    parameter int AUTOFIRE_HALF = 2400000
) (
    input logic               clk_sys,
    input logic               reset_n,
    arcade_input_ctrl_if.slave io
);
    logic       r_tog, r_prime;
    logic [5:0] r_p1_keys, r_p2_keys, w_p1_keys_nxt, w_p2_keys_nxt;
    logic       r_start1, r_start2, r_coin1, r_coin2;
    logic       w_start1_nxt, w_start2_nxt, w_coin1_nxt, w_coin2_nxt;
    logic [5:0] r_inp0, r_inp1, w_p1, w_p2, w_p1_g, w_p2_g;
    logic [1:0] r_inp2;
    logic       w_event, w_prs, w_start1, w_start2, w_coin_raw, w_coin, w_busy;
    logic       w_phase, w_gate;
    logic [8:0] w_code;
    logic       w_unused;

    assign w_code   = io.ps2_key[8:0];
    assign w_prs    = io.ps2_key[9];
    assign w_event  = r_prime && (r_tog != io.ps2_key[10]);
    assign w_unused = ^{io.joystk1[15:9], io.joystk2[15:9]};

    always_comb begin
        w_p1_keys_nxt = r_p1_keys;
        w_p2_keys_nxt = r_p2_keys;
        w_start1_nxt  = r_start1;
        w_start2_nxt  = r_start2;
        w_coin1_nxt   = r_coin1;
        w_coin2_nxt   = r_coin2;
        if (w_event) begin
            // Arrow keys match with or without the extended prefix bit.
            if (w_code[7:0] == KEY_UP[7:0])         w_p1_keys_nxt[INP_UP]    = w_prs;
            else if (w_code[7:0] == KEY_DOWN[7:0])  w_p1_keys_nxt[INP_DOWN]  = w_prs;
            else if (w_code[7:0] == KEY_LEFT[7:0])  w_p1_keys_nxt[INP_LEFT]  = w_prs;
            else if (w_code[7:0] == KEY_RIGHT[7:0]) w_p1_keys_nxt[INP_RIGHT] = w_prs;
            else begin
                case (w_code)
                    KEY_P1_TRIG1: w_p1_keys_nxt[INP_TRIG1] = w_prs;
                    KEY_P1_TRIG2: w_p1_keys_nxt[INP_TRIG2] = w_prs;
                    KEY_P2_UP:    w_p2_keys_nxt[INP_UP]    = w_prs;
                    KEY_P2_DOWN:  w_p2_keys_nxt[INP_DOWN]  = w_prs;
                    KEY_P2_LEFT:  w_p2_keys_nxt[INP_LEFT]  = w_prs;
                    KEY_P2_RIGHT: w_p2_keys_nxt[INP_RIGHT] = w_prs;
                    KEY_P2_TRIG1: w_p2_keys_nxt[INP_TRIG1] = w_prs;
                    KEY_P2_TRIG2: w_p2_keys_nxt[INP_TRIG2] = w_prs;
                    KEY_F1:       begin w_start1_nxt = w_prs; w_coin1_nxt = w_prs; end
                    KEY_F2:       begin w_start2_nxt = w_prs; w_coin2_nxt = w_prs; end
                    KEY_START1:   w_start1_nxt = w_prs;
                    KEY_START2:   w_start2_nxt = w_prs;
                    KEY_COIN1:    w_coin1_nxt  = w_prs;
                    KEY_COIN2:    w_coin2_nxt  = w_prs;
                    default:      ;
                endcase
            end
        end
    end

    assign w_p2       = r_p2_keys | joy_to_inp(io.joystk2[5:0]);
    assign w_p1       = r_p1_keys | joy_to_inp(io.joystk1[5:0]) | (io.cabinet ? 6'd0 : w_p2);
    assign w_start1   = r_start1 | io.joystk1[JOY_START1] | io.joystk2[JOY_START1];
    assign w_start2   = r_start2 | io.joystk1[JOY_START2] | io.joystk2[JOY_START2];
    assign w_coin_raw = r_coin1 | r_coin2 | io.joystk1[JOY_COIN] | io.joystk2[JOY_COIN];

`ifdef ARC_INPUT_AUTOFIRE_EN
    localparam int AFW = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;
    logic [AFW-1:0] r_af_cnt;
    logic           r_phase;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_af_cnt <= AFW'(AUTOFIRE_HALF - 1);
            r_phase  <= 1'b1;
        end else if (r_af_cnt == '0) begin
            r_af_cnt <= AFW'(AUTOFIRE_HALF - 1);
            r_phase  <= ~r_phase;
        end else begin
            r_af_cnt <= r_af_cnt - AFW'(1);
        end
    end

    assign w_phase = r_phase;
`else
    // Without the feature the phase is a constant 1, so trig1 is never gated.
    assign w_phase = (AUTOFIRE_HALF > 0);
`endif

    assign w_gate = ~io.autofire | w_phase;

    always_comb begin
        w_p1_g = w_p1;
        w_p2_g = w_p2;
        w_p1_g[INP_TRIG1] = w_p1[INP_TRIG1] & w_gate;
        w_p2_g[INP_TRIG1] = w_p2[INP_TRIG1] & w_gate;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_tog     <= 1'b0;
            r_prime   <= 1'b0;
            r_p1_keys <= '0;
            r_p2_keys <= '0;
            r_start1  <= 1'b0;
            r_start2  <= 1'b0;
            r_coin1   <= 1'b0;
            r_coin2   <= 1'b0;
            r_inp0    <= '0;
            r_inp1    <= '0;
            r_inp2    <= '0;
        end else begin
            r_tog     <= io.ps2_key[10];
            r_prime   <= 1'b1;
            r_p1_keys <= w_p1_keys_nxt;
            r_p2_keys <= w_p2_keys_nxt;
            r_start1  <= w_start1_nxt;
            r_start2  <= w_start2_nxt;
            r_coin1   <= w_coin1_nxt;
            r_coin2   <= w_coin2_nxt;
            r_inp0    <= w_p1_g;
            r_inp1    <= w_p2_g;
            r_inp2    <= {w_start2, w_start1};
        end
    end

    coin_pulser #(
        .COIN_ON     (COIN_ON),
        .COIN_OFF    (COIN_OFF),
        .MAX_PENDING (MAX_PENDING)
    ) u_coin (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .i_coin_raw (w_coin_raw),
        .o_coin     (w_coin),
        .o_busy     (w_busy)
    );

    assign io.INP0      = r_inp0;
    assign io.INP1      = r_inp1;
    assign io.INP2      = {w_coin, r_inp2};
    assign io.coin_busy = w_busy;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Self-checking bench for arcade_input_ctrl with short coin/autofire timings.
module tb_arcade_input_ctrl;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl_if bus();

    arcade_input_ctrl #(
        .COIN_ON       (4),
        .COIN_OFF      (3),
        .MAX_PENDING   (3),
        .AUTOFIRE_HALF (2)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .io      (bus)
    );

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    logic [13:0] key_q[$];
    int coin_q[$];

    // Coin scoreboard: every completed pulse pops one expected high length.
    bit prev_coin = 0;
    bit seen_pulse = 0;
    int hi_len = 0;
    int lo_len = 0;
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_coin = 0; hi_len = 0; lo_len = 0; seen_pulse = 0;
        end else if (bus.INP2[2] === 1'b1) begin
            if (!prev_coin && seen_pulse) begin
                checks++;
                if (lo_len < 4) begin
                    errors++;
                    $display("FAIL coin_gap low=%0d required>=4", lo_len);
                end
            end
            hi_len++;
            prev_coin = 1;
        end else begin
            if (prev_coin) begin
                pulse_cnt++;
                checks++;
                if (coin_q.size() == 0) begin
                    errors++;
                    $display("FAIL coin_unexpected high=%0d required no pulse", hi_len);
                end else begin
                    int exp_len;
                    exp_len = coin_q.pop_front();
                    if (hi_len != exp_len) begin
                        errors++;
                        $display("FAIL coin_len high=%0d required=%0d", hi_len, exp_len);
                    end
                end
                hi_len = 0; lo_len = 0; seen_pulse = 1;
            end
            lo_len++;
            prev_coin = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic ps2_send(input logic [8:0] code, input logic prs);
        bus.ps2_key = {~bus.ps2_key[10], prs, code};
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && bus.coin_busy; i++) tick(1);
        checks++;
        if (bus.coin_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_timeout busy=%b required=0", name, bus.coin_busy);
        end
        checks++;
        if (coin_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_pulses left=%0d required=0", name, coin_q.size());
        end
    endtask

    task automatic test_reset;
        #22;
        checks++;
        if ({bus.INP0, bus.INP1, bus.INP2, bus.coin_busy} !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0000",
                     {bus.INP0, bus.INP1, bus.INP2, bus.coin_busy});
        end
        @(negedge clk_sys) reset_n = 1'b1;
        tick(3);
        checks++;
        if (bus.INP0 !== 6'd0) begin
            errors++;
            $display("FAIL reset_prime_no_key INP0=%b required=000000", bus.INP0);
        end
    endtask

    task automatic test_key_latency;
        ps2_send(9'h029, 1'b1);
        tick(1);
        checks++;
        if (bus.INP0[4] !== 1'b0) begin
            errors++;
            $display("FAIL key_latency_early INP0[4]=%b required=0", bus.INP0[4]);
        end
        tick(1);
        checks++;
        if (bus.INP0[4] !== 1'b1) begin
            errors++;
            $display("FAIL key_press_trig1 INP0[4]=%b required=1", bus.INP0[4]);
        end
        ps2_send(9'h029, 1'b0);
        tick(2);
        checks++;
        if (bus.INP0 !== 6'd0) begin
            errors++;
            $display("FAIL key_release_trig1 INP0=%b required=000000", bus.INP0);
        end
    endtask

    task automatic test_key_map;
        logic [8:0]  codes [0:17];
        logic [13:0] exps  [0:17];
        logic [13:0] exp_v, got;
        codes = '{9'h029, 9'h014, 9'h075, 9'h172, 9'h06B, 9'h174,
                  9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h01B,
                  9'h016, 9'h01E, 9'h005, 9'h006, 9'h0FF, 9'h136};
        exps  = '{{6'b010000, 6'b000000, 2'b00}, {6'b100000, 6'b000000, 2'b00},
                  {6'b000001, 6'b000000, 2'b00}, {6'b000100, 6'b000000, 2'b00},
                  {6'b001000, 6'b000000, 2'b00}, {6'b000010, 6'b000000, 2'b00},
                  {6'b000000, 6'b000001, 2'b00}, {6'b000000, 6'b000100, 2'b00},
                  {6'b000000, 6'b001000, 2'b00}, {6'b000000, 6'b000010, 2'b00},
                  {6'b000000, 6'b010000, 2'b00}, {6'b000000, 6'b100000, 2'b00},
                  {6'b000000, 6'b000000, 2'b01}, {6'b000000, 6'b000000, 2'b10},
                  {6'b000000, 6'b000000, 2'b01}, {6'b000000, 6'b000000, 2'b10},
                  {6'b000000, 6'b000000, 2'b00}, {6'b000000, 6'b000000, 2'b00}};
        bus.cabinet = 1'b1;
        for (int i = 0; i < 18; i++) begin
            ps2_send(codes[i], 1'b1);
            if (codes[i] == 9'h005 || codes[i] == 9'h006) coin_q.push_back(4);
            key_q.push_back(exps[i]);
            tick(2);
            exp_v = key_q.pop_front();
            got = {bus.INP0, bus.INP1, bus.INP2[1:0]};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL keymap_press code=%h got=%b required=%b", codes[i], got, exp_v);
            end
            ps2_send(codes[i], 1'b0);
            key_q.push_back(14'd0);
            tick(2);
            exp_v = key_q.pop_front();
            got = {bus.INP0, bus.INP1, bus.INP2[1:0]};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL keymap_release code=%h got=%b required=%b", codes[i], got, exp_v);
            end
        end
        wait_idle("keymap");
    endtask

    task automatic test_cabinet;
        bus.cabinet = 1'b0;
        bus.joystk2 = 16'h0008;
        tick(1);
        checks++;
        if (bus.INP0[0] !== 1'b1 || bus.INP1[0] !== 1'b1) begin
            errors++;
            $display("FAIL cabinet_upright INP0[0]=%b INP1[0]=%b required=1 1", bus.INP0[0], bus.INP1[0]);
        end
        bus.cabinet = 1'b1;
        tick(1);
        checks++;
        if (bus.INP0[0] !== 1'b0 || bus.INP1[0] !== 1'b1) begin
            errors++;
            $display("FAIL cabinet_cocktail INP0[0]=%b INP1[0]=%b required=0 1", bus.INP0[0], bus.INP1[0]);
        end
        bus.joystk2 = 16'h0080;
        bus.joystk1 = 16'h0041;
        tick(1);
        checks++;
        if ({bus.INP0, bus.INP1, bus.INP2[1:0]} !== {6'b000010, 6'b000000, 2'b11}) begin
            errors++;
            $display("FAIL joy_layout got=%b required=%b",
                     {bus.INP0, bus.INP1, bus.INP2[1:0]}, {6'b000010, 6'b000000, 2'b11});
        end
        bus.joystk1 = 16'h0000;
        bus.joystk2 = 16'h0000;
        tick(2);
    endtask

    task automatic test_coin_single;
        int n;
        int base;
        base = pulse_cnt;
        ps2_send(9'h02E, 1'b1);
        coin_q.push_back(4);
        tick(1);
        ps2_send(9'h02E, 1'b0);
        for (int i = 0; i < 20 && bus.INP2[2] !== 1'b1; i++) tick(1);
        for (int i = 0; i < 20 && bus.INP2[2] !== 1'b0; i++) tick(1);
        n = 0;
        while (bus.coin_busy === 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL coin_single_busy_tail cycles=%0d required=3", n);
        end
        wait_idle("coin_single");
        checks++;
        if (pulse_cnt - base != 1) begin
            errors++;
            $display("FAIL coin_single_count pulses=%0d required=1", pulse_cnt - base);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        base = pulse_cnt;
        for (int i = 0; i < 4; i++) coin_q.push_back(4);
        for (int i = 0; i < 5; i++) begin
            bus.joystk1 = 16'h0100;
            tick(1);
            bus.joystk1 = 16'h0000;
            tick(1);
        end
        wait_idle("back_to_back");
        checks++;
        if (pulse_cnt - base != 4) begin
            errors++;
            $display("FAIL back_to_back_count pulses=%0d required=4", pulse_cnt - base);
        end
    endtask

    task automatic test_reset_mid;
        int base;
        for (int i = 0; i < 2; i++) begin
            bus.joystk1 = 16'h0100;
            tick(1);
            bus.joystk1 = 16'h0000;
            tick(1);
        end
        for (int i = 0; i < 20 && bus.INP2[2] !== 1'b1; i++) tick(1);
        tick(1);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.INP2[2] !== 1'b0 || bus.coin_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_immediate coin=%b busy=%b required=0 0", bus.INP2[2], bus.coin_busy);
        end
        coin_q.delete();
        tick(2);
        @(negedge clk_sys) reset_n = 1'b1;
        base = pulse_cnt;
        tick(20);
        checks++;
        if (pulse_cnt != base || bus.coin_busy !== 1'b0 || prev_coin) begin
            errors++;
            $display("FAIL reset_mid_residual pulses=%0d busy=%b required=0 0", pulse_cnt - base, bus.coin_busy);
        end
    endtask

    task automatic test_autofire;
        logic s [0:7];
        bit steady;
        bus.cabinet  = 1'b1;
        bus.autofire = 1'b0;
        bus.joystk1  = 16'h0010;
        tick(2);
        steady = 1;
        for (int i = 0; i < 6; i++) begin
            if (bus.INP0[4] !== 1'b1) steady = 0;
            tick(1);
        end
        checks++;
        if (!steady) begin
            errors++;
            $display("FAIL autofire_off_steady INP0[4] dropped required=1");
        end
        bus.autofire = 1'b1;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            s[i] = bus.INP0[4];
            tick(1);
        end
`ifdef ARC_INPUT_AUTOFIRE_EN
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (s[i] === s[i + 2]) begin
                errors++;
                $display("FAIL autofire_toggle idx=%0d got=%b required=%b", i + 2, s[i + 2], ~s[i]);
            end
        end
`else
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (s[i] !== 1'b1) begin
                errors++;
                $display("FAIL autofire_ignored idx=%0d got=%b required=1", i, s[i]);
            end
        end
`endif
        bus.autofire = 1'b0;
        bus.joystk1  = 16'h0000;
        tick(2);
    endtask

    initial begin
        bus.ps2_key  = {1'b1, 1'b1, 9'h029};
        bus.joystk1  = 16'h0000;
        bus.joystk2  = 16'h0000;
        bus.cabinet  = 1'b1;
        bus.autofire = 1'b0;
        test_reset;
        test_key_latency;
        test_key_map;
        test_cabinet;
        test_coin_single;
        test_back_to_back;
        test_reset_mid;
        test_autofire;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
